quire_to_posit: RTL and testbench
=================================

# quire_to_posit

Converts the accumulated quire value produced by the quire accumulator into a POSIT_WIDTH-bit posit at the end of each accumulation window. It sits directly downstream of the quire and upstream of the posit output / write-back stage. Only beats flagged end-of-window are converted; intermediate partial sums are consumed and discarded. It is a 3-stage pipeline with the codebase's rts/rtr handshake and a one-entry input skid latch.

## Interface
- POSIT_WIDTH, 4, output posit width n
- POSIT_ES, 0, exponent size es
- LOG_NB_ACCUM, 10, quire carry-guard bits; must match the upstream quire
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- rts_i  in  1  upstream has a valid beat
- rtr_o  out  1  ready to receive, registered
- sow_i  in  1  start of window; accepted and ignored
- eow_i  in  1  end of window; only these beats are converted
- data_i  in  QUIRE_SIZE  two's-complement quire; QUIRE_SIZE = 2^(es+2)*(n-2)+1+LOG_NB_ACCUM
- sign_i, zero_i, NaR_i  in  1 each  quire flags
- rtr_i  in  1  downstream ready
- rts_o  out  1  posit_o valid
- posit_o  out  POSIT_WIDTH  converted posit
- NaR_o, zero_o  out  1 each  flags of posit_o

## Operation
- Fixed point: binary point bpp = (2^(es+2)*(n-2))/2 bits above the quire LSB. maxscale = (n-2)*2^es.
- Handshake:
  - process_en = rtr_i | ~rts_o.
  - receive_en = rts_i & rtr_o.
  - rtr_o <= process_en every cycle.
  - If receive_en & ~process_en, the beat goes into the skid latch. The latch is consumed first once process_en returns.
- Stage 1 accepts a beat when process_en & (receive_en | latched). The beat is marked valid only if eow=1; non-eow beats produce a bubble.
- S1: absolute value over QUIRE_SIZE+1 bits, which covers the most negative quire. Registers sign, zero, NaR.
- S2: leading-one detect over the magnitude, giving msb index p.
  - scale = p - bpp, signed.
  - Left-normalise the magnitude so the hidden bit is at the top. Keep the fraction bits plus guard and sticky (OR of all lower bits).
- S3: encode the posit.
  - Regime k = scale >> es (arithmetic); exponent e = scale mod 2^es.
  - Regime run = k+1 ones then a 0 for k≥0; -k zeros then a 1 for k<0.
  - Concatenate regime, e, fraction; truncate to n-1 bits; round per Configuration.
  - Apply two's complement if sign.
- Special cases, in priority order:
  - NaR → 1 followed by zeros; NaR_o=1.
  - zero → all zeros; zero_o=1.
  - scale > maxscale, or rounding overflows → maxpos (0 then ones).
  - scale < -maxscale → minpos (0…01).
  - A nonzero quire never rounds to 0. A non-NaR quire never rounds to NaR.
- Downstream stage advances only on process_en. Output holds stable while rts_o & ~rtr_i.

## Timing
- Latency: 3 cycles from accepted eow beat to rts_o.
- Throughput: 1 beat/cycle when rtr_i=1.
- Reset values: rtr_o=0, rts_o=0, posit_o=0, NaR_o=0, zero_o=0. Skid latch and all stage-valid bits are cleared.
- rtr_o rises one cycle after reset release.
- Reset mid-operation: all in-flight beats are discarded and rts_o drops immediately (asynchronous).
- Back-to-back eow beats with rtr_i low: up to 3 pipelined results plus 1 latched beat are held, and none is lost.
- rtr_i and rts_i toggling in the same cycle: the latch is written only when receive_en & ~process_en.

## Configuration
- QUIRE_TO_POSIT_RNE_EN defined: round-to-nearest, ties-to-even, using guard/round/sticky. Saturation rules still apply.
- Not defined: truncation toward zero of the magnitude. Guard and sticky logic are removed.

## Test plan
(n=4, es=0, LOG_NB_ACCUM=10: QUIRE_SIZE=19, bpp=4.)
- data=0x00010, eow=1 → posit 0x4 (1.0) after 3 cycles. data=0x00018 → 0x5 (1.5).
- data=0x00016 (1.375) → 0x5 with RNE_EN; 0x4 without. data=0x00014 (1.25, tie) → 0x4 both ways.
- data=-0x00018 with sign=1 → 0xB. data=0x00640 (100.0) → 0x7 maxpos. data=0x00001 (0.0625) → 0x1 minpos.
- NaR_i=1 → 0x8 with NaR_o=1. zero_i=1 → 0x0 with zero_o=1.
- Stream of 8 beats with eow only on beats 4 and 8 → exactly 2 outputs, in order.
- rtr_i held low 10 cycles during a stream of 6 eow beats, then released → all 6 results delivered in order, no duplicates. rtr_o is low while stalled.

Source files
------------

// File: rtl/quire_to_posit.sv
// quire_to_posit: converts the end-of-window quire value into a posit.
// Pipeline: S1 absolute value, S2 leading-one detect + normalise, S3 regime encode + round.
// A one-entry skid latch catches the beat that arrives while the pipeline stalls.
// Build option: define QUIRE_TO_POSIT_RNE_EN for round-to-nearest-even; otherwise the
// magnitude is truncated toward zero.
// Handshake: a beat moves whenever the sender's rts and the receiver's rtr are both high at
// the rising edge; the sender holds its beat stable until then, and rtr_o is a registered
// copy of process_en (rtr_i | ~rts_o).

module quire_to_posit #(
    parameter int POSIT_WIDTH    = 4,
    parameter int POSIT_ES       = 0,
    parameter int LOG_NB_ACCUM   = 10,
    localparam int QUIRE_SIZE    = (1 << (POSIT_ES + 2)) * (POSIT_WIDTH - 2) + 1 + LOG_NB_ACCUM
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rts_i,
    output logic                   rtr_o,
    input  logic                   sow_i,
    input  logic                   eow_i,
    input  logic [QUIRE_SIZE-1:0]  data_i,
    input  logic                   sign_i,
    input  logic                   zero_i,
    input  logic                   NaR_i,
    input  logic                   rtr_i,
    output logic                   rts_o,
    output logic [POSIT_WIDTH-1:0] posit_o,
    output logic                   NaR_o,
    output logic                   zero_o
);

    localparam int N        = POSIT_WIDTH;
    localparam int ES       = POSIT_ES;
    localparam int QS       = QUIRE_SIZE;
    localparam int MW       = QS + 1;                              // magnitude incl. most-negative quire
    localparam int BPP      = ((1 << (ES + 2)) * (N - 2)) / 2;     // binary point above quire LSB
    localparam int MAXSCALE = (N - 2) * (1 << ES);
    localparam int PW       = $clog2(MW);
    localparam int SW       = PW + 2;                              // signed scale width
    localparam int F        = N - 1;                               // fraction bits kept after hidden bit
    localparam int BW       = N + ES + F;                          // regime + exponent + fraction body

    localparam logic signed [SW-1:0] BPP_S  = SW'(BPP);
    localparam logic signed [SW-1:0] MAXS   = SW'(MAXSCALE);
    localparam logic signed [SW-1:0] MINS   = -MAXS;
    localparam logic [N-1:0]         MAXPOS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]         MINPOS = N'(1);
    localparam logic [N-1:0]         NARPOS = {1'b1, {(N-1){1'b0}}};

    // Handshake and skid latch
    logic            r_rtr;
    logic            r_lat_v;
    logic [QS-1:0]   r_lat_data;
    logic            r_lat_eow, r_lat_sign, r_lat_zero, r_lat_nar;
    logic            w_process_en, w_receive_en, w_take;
    logic [QS-1:0]   w_in_data;
    logic            w_in_eow, w_in_sign, w_in_zero, w_in_nar;
    logic [MW-1:0]   w_sext, w_abs;

    // Stage registers
    logic            r_s1_v, r_s1_sign, r_s1_zero, r_s1_nar;
    logic [MW-1:0]   r_s1_mag;
    logic            r_s2_v, r_s2_sign, r_s2_zero, r_s2_nar;
    logic signed [SW-1:0] r_s2_scale;
    logic [F-1:0]    r_s2_frac;
    logic            r_s3_v, r_nar, r_zero;
    logic [N-1:0]    r_posit;

    // Stage 2 / 3 combinational
    logic [PW-1:0]   w_p;
    logic [MW-1:0]   w_norm;
    logic signed [SW-1:0] w_scale, w_k;
    logic [SW-1:0]   w_rsh, w_rl;
    logic [ES+F-1:0] w_ef;
    logic [BW-1:0]   w_regime, w_body;
    logic [N-1:0]    w_mag_t, w_mag_r, w_sat, w_posit;
    logic            w_round_up;
    logic            w_unused;

    assign w_process_en = rtr_i | ~r_s3_v;
    assign w_receive_en = rts_i & r_rtr;
    assign w_take       = w_process_en & (w_receive_en | r_lat_v);

    // The latched beat always goes ahead of anything new on the inputs.
    always_comb begin
        if (r_lat_v) begin
            w_in_data = r_lat_data;
            w_in_eow  = r_lat_eow;
            w_in_sign = r_lat_sign;
            w_in_zero = r_lat_zero;
            w_in_nar  = r_lat_nar;
        end else begin
            w_in_data = data_i;
            w_in_eow  = eow_i;
            w_in_sign = sign_i;
            w_in_zero = zero_i;
            w_in_nar  = NaR_i;
        end
    end

    assign w_sext = {w_in_data[QS-1], w_in_data};
    assign w_abs  = w_sext[MW-1] ? (~w_sext + MW'(1)) : w_sext;

    // Register rtr_o and park a beat that arrives while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rtr      <= 1'b0;
            r_lat_v    <= 1'b0;
            r_lat_data <= '0;
            r_lat_eow  <= 1'b0;
            r_lat_sign <= 1'b0;
            r_lat_zero <= 1'b0;
            r_lat_nar  <= 1'b0;
        end else begin
            r_rtr <= w_process_en;
            if (w_receive_en && !w_process_en) begin
                r_lat_v    <= 1'b1;
                r_lat_data <= data_i;
                r_lat_eow  <= eow_i;
                r_lat_sign <= sign_i;
                r_lat_zero <= zero_i;
                r_lat_nar  <= NaR_i;
            end else if (w_process_en) begin
                r_lat_v <= 1'b0;
            end
        end
    end

    // Leading-one detect: the highest set bit wins.
    always_comb begin
        w_p = '0;
        for (int i = 0; i < MW; i++) begin
            if (r_s1_mag[i]) w_p = PW'(i);
        end
    end

    assign w_norm  = r_s1_mag << (PW'(MW - 1) - w_p);
    assign w_scale = $signed({2'b00, w_p}) - BPP_S;

    // Build the left-aligned posit body: regime run, exponent, fraction.
    always_comb begin
        w_k  = r_s2_scale >>> ES;
        w_ef = '0;
        w_ef[F-1:0] = r_s2_frac;
        for (int i = 0; i < ES; i++) begin
            w_ef[F+i] = r_s2_scale[i];
        end
        if (!w_k[SW-1]) begin
            w_rsh    = $unsigned(w_k) + SW'(1);
            w_rl     = $unsigned(w_k) + SW'(2);
            w_regime = ~({BW{1'b1}} >> w_rsh);
        end else begin
            w_rsh    = $unsigned(-w_k);
            w_rl     = w_rsh + SW'(1);
            w_regime = {1'b1, {(BW-1){1'b0}}} >> w_rsh;
        end
        w_body = w_regime | ({w_ef, {N{1'b0}}} >> w_rl);
    end

    assign w_mag_t = {1'b0, w_body[BW-1 -: N-1]};

`ifdef QUIRE_TO_POSIT_RNE_EN
    logic r_s2_sticky;
    logic w_guard, w_sticky;
    assign w_guard    = w_body[BW-N];
    assign w_sticky   = (|w_body[BW-N-1:0]) | r_s2_sticky;
    assign w_round_up = w_guard & (w_body[BW-N+1] | w_sticky);
    assign w_unused   = ^{sow_i, w_norm[MW-1]};
`else
    assign w_round_up = 1'b0;
    assign w_unused   = ^{sow_i, w_norm[MW-1], w_norm[MW-2-F:0], w_body[BW-N:0]};
`endif

    assign w_mag_r = w_mag_t + N'(w_round_up);

    // Saturate, then apply the special cases and the sign.
    always_comb begin
        if (r_s2_scale > MAXS || w_mag_r[N-1]) begin
            w_sat = MAXPOS;
        end else if (r_s2_scale < MINS || w_mag_r == '0) begin
            w_sat = MINPOS;
        end else begin
            w_sat = w_mag_r;
        end
        if (r_s2_nar) begin
            w_posit = NARPOS;
        end else if (r_s2_zero) begin
            w_posit = '0;
        end else if (r_s2_sign) begin
            w_posit = ~w_sat + N'(1);
        end else begin
            w_posit = w_sat;
        end
    end

    // All three stages advance together whenever the output slot is free or being taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v     <= 1'b0;
            r_s1_mag   <= '0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_nar   <= 1'b0;
            r_s2_v     <= 1'b0;
            r_s2_scale <= '0;
            r_s2_frac  <= '0;
            r_s2_sign  <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_nar   <= 1'b0;
`ifdef QUIRE_TO_POSIT_RNE_EN
            r_s2_sticky <= 1'b0;
`endif
            r_s3_v     <= 1'b0;
            r_posit    <= '0;
            r_nar      <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_process_en) begin
            r_s1_v     <= w_take & w_in_eow;
            r_s1_mag   <= w_abs;
            r_s1_sign  <= w_in_sign;
            r_s1_zero  <= w_in_zero | (w_in_data == '0);
            r_s1_nar   <= w_in_nar;
            r_s2_v     <= r_s1_v;
            r_s2_scale <= w_scale;
            r_s2_frac  <= w_norm[MW-2 -: F];
            r_s2_sign  <= r_s1_sign;
            r_s2_zero  <= r_s1_zero;
            r_s2_nar   <= r_s1_nar;
`ifdef QUIRE_TO_POSIT_RNE_EN
            r_s2_sticky <= |w_norm[MW-2-F:0];
`endif
            r_s3_v     <= r_s2_v;
            r_posit    <= w_posit;
            r_nar      <= r_s2_nar;
            r_zero     <= ~r_s2_nar & r_s2_zero;
        end
    end

    assign rtr_o   = r_rtr;
    assign rts_o   = r_s3_v;
    assign posit_o = r_posit;
    assign NaR_o   = r_nar;
    assign zero_o  = r_zero;

endmodule

// File: tb/tb_quire_to_posit.sv
// Testbench for quire_to_posit at n=4, es=0, LOG_NB_ACCUM=10 (19-bit quire, LSB weight 2^-4).
// Expected posits come from a value table of posit<4,0>, independent of the encoder structure.

module tb_quire_to_posit;

    logic        clk;
    logic        rst_n;
    logic        rts_i;
    logic        rtr_o;
    logic        sow_i;
    logic        eow_i;
    logic [18:0] data_i;
    logic        sign_i;
    logic        zero_i;
    logic        NaR_i;
    logic        rtr_i;
    logic        rts_o;
    logic [3:0]  posit_o;
    logic        NaR_o;
    logic        zero_o;

    int          tests_run = 0;
    int          fails     = 0;
    int          n_out     = 0;
    int          n_mark;
    int          waitn;
    logic        rand_done;
    logic [5:0]  exp_q[$];
    logic [5:0]  exp_v;

    quire_to_posit #(
        .POSIT_WIDTH  (4),
        .POSIT_ES     (0),
        .LOG_NB_ACCUM (10)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rts_i   (rts_i),
        .rtr_o   (rtr_o),
        .sow_i   (sow_i),
        .eow_i   (eow_i),
        .data_i  (data_i),
        .sign_i  (sign_i),
        .zero_i  (zero_i),
        .NaR_i   (NaR_i),
        .rtr_i   (rtr_i),
        .rts_o   (rts_o),
        .posit_o (posit_o),
        .NaR_o   (NaR_o),
        .zero_o  (zero_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests_run, fails);
        $fatal(1, "watchdog");
    end

    // Reference: {NaR, zero, posit}. Positive posit<4,0> codes 1..7 are
    // 0.25, 0.5, 0.75, 1, 1.5, 2, 4; the table holds them scaled by 16.
    function automatic logic [5:0] ref_out(input logic [18:0] d, input logic nar, input logic zero);
        int         tbl [0:7];
        longint     m;
        int         c;
        logic [3:0] code;
        tbl = '{0, 4, 8, 12, 16, 24, 32, 64};
        if (nar) return 6'b10_1000;
        if (zero) return 6'b01_0000;
        m = longint'($signed(d));
        if (m < 0) m = -m;
        if (m >= 64) begin
            c = 7;
        end else if (m < 4) begin
            c = 1;
        end else begin
            c = 1;
            for (int i = 1; i < 7; i++) begin
                if (longint'(tbl[i]) <= m) c = i;
            end
`ifdef QUIRE_TO_POSIT_RNE_EN
            if (2 * m > longint'(tbl[c] + tbl[c+1])) c = c + 1;
            else if (2 * m == longint'(tbl[c] + tbl[c+1]) && (c % 2) == 1) c = c + 1;
`endif
        end
        code = 4'(c);
        if (d[18]) code = 4'(16 - c);
        return {2'b00, code};
    endfunction

    function automatic logic [18:0] rand_quire();
        int unsigned mag;
        logic [18:0] r;
        mag = $urandom_range(1, 262143);
        mag = mag >> $urandom_range(0, 17);
        if (mag == 0) mag = 1;
        r = 19'(mag);
        if ($urandom_range(0, 1) == 1) r = -r;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver: called right after a falling edge; holds the beat until rtr_o accepts it.
    task automatic send(input logic [18:0] d, input logic sow, input logic eow,
                        input logic nar, input logic zero);
        int waited;
        waited = 0;
        rts_i  = 1'b1;
        data_i = d;
        sow_i  = sow;
        eow_i  = eow;
        sign_i = d[18];
        zero_i = zero;
        NaR_i  = nar;
        while (rtr_o !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("accept_timeout", 32'(rtr_o), 32'd1);
        if (rtr_o === 1'b1 && eow) exp_q.push_back(ref_out(d, nar, zero));
        @(negedge clk);
        rts_i = 1'b0;
        sow_i = 1'b0;
        eow_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rtr_i = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: an output transfers when rts_o & rtr_i at the next rising edge.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && rts_o && rtr_i) begin
            n_out++;
            tests_run++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_out: got %0h expected none", {NaR_o, zero_o, posit_o});
            end
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                tests_run++;
                assert ({NaR_o, zero_o, posit_o} === exp_v) else begin
                    fails++;
                    $error("FAIL out_value: got %0h expected %0h", {NaR_o, zero_o, posit_o}, exp_v);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        rts_i     = 1'b0;
        sow_i     = 1'b0;
        eow_i     = 1'b0;
        data_i    = '0;
        sign_i    = 1'b0;
        zero_i    = 1'b0;
        NaR_i     = 1'b0;
        rtr_i     = 1'b1;
        rand_done = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_rtr_o", 32'(rtr_o), 32'd0);
        check("reset_rts_o", 32'(rts_o), 32'd0);
        check("reset_posit", 32'(posit_o), 32'd0);
        check("reset_nar", 32'(NaR_o), 32'd0);
        check("reset_zero", 32'(zero_o), 32'd0);
        rst_n = 1'b1;
        check("rtr_before_edge", 32'(rtr_o), 32'd0);
        @(negedge clk);
        check("rtr_after_release", 32'(rtr_o), 32'd1);

        // Latency: 1.0 appears three edges after acceptance
        send(19'h00010, 1'b1, 1'b1, 1'b0, 1'b0);
        check("latency_c1", 32'(rts_o), 32'd0);
        @(negedge clk);
        check("latency_c2", 32'(rts_o), 32'd0);
        @(negedge clk);
        check("latency_c3", 32'(rts_o), 32'd1);
        @(negedge clk);

        // Directed values: 1.5, 1.375, 1.25 tie, -1.5, 100, 0.0625, most negative, NaR, zero
        send(19'h00018, 1'b0, 1'b1, 1'b0, 1'b0);
        send(19'h00016, 1'b0, 1'b1, 1'b0, 1'b0);
        send(19'h00014, 1'b0, 1'b1, 1'b0, 1'b0);
        send(19'h7FFE8, 1'b0, 1'b1, 1'b0, 1'b0);
        send(19'h00640, 1'b0, 1'b1, 1'b0, 1'b0);
        send(19'h00001, 1'b0, 1'b1, 1'b0, 1'b0);
        send(19'h40000, 1'b0, 1'b1, 1'b0, 1'b0);
        send(19'h00006, 1'b0, 1'b1, 1'b0, 1'b0);
        send(19'h00030, 1'b0, 1'b1, 1'b0, 1'b0);
        send(19'h00123, 1'b0, 1'b1, 1'b1, 1'b0);
        send(19'h00000, 1'b0, 1'b1, 1'b0, 1'b1);
        drain();

        // Window stream: eow only on beats 4 and 8
        n_mark = n_out;
        for (int i = 1; i <= 8; i++) begin
            send(rand_quire(), (i == 1 || i == 5), (i == 4 || i == 8), 1'b0, 1'b0);
        end
        drain();
        check("window_out_count", 32'(n_out - n_mark), 32'd2);

        // Stall: rtr_i low for 10 cycles during 6 back-to-back eow beats
        n_mark = n_out;
        rtr_i  = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(rand_quire(), 1'b0, 1'b1, 1'b0, 1'b0);
                end
            end
            begin
                repeat (6) @(negedge clk);
                check("stall_rtr_low", 32'(rtr_o), 32'd0);
                check("stall_rts_high", 32'(rts_o), 32'd1);
                check("stall_hold_a", 32'({NaR_o, zero_o, posit_o}), 32'(exp_q[0]));
                repeat (3) @(negedge clk);
                check("stall_hold_b", 32'({NaR_o, zero_o, posit_o}), 32'(exp_q[0]));
                @(negedge clk);
                rtr_i = 1'b1;
            end
        join
        drain();
        check("stall_out_count", 32'(n_out - n_mark), 32'd6);

        // Reset mid-operation drops rts_o at once
        rtr_i = 1'b0;
        send(19'h00018, 1'b0, 1'b1, 1'b0, 1'b0);
        send(19'h00020, 1'b0, 1'b1, 1'b0, 1'b0);
        waitn = 0;
        while (rts_o !== 1'b1 && waitn < 10) begin
            @(negedge clk);
            waitn++;
        end
        check("pre_reset_rts", 32'(rts_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_rts", 32'(rts_o), 32'd0);
        check("async_reset_rtr", 32'(rtr_o), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rtr_i = 1'b1;
        @(negedge clk);
        check("post_reset_rts", 32'(rts_o), 32'd0);

        // Random beats with random downstream backpressure
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    case ($urandom_range(0, 15))
                        0:       send(rand_quire(), 1'b0, ($urandom_range(0, 3) != 0), 1'b1, 1'b0);
                        1:       send(19'h00000, 1'b0, ($urandom_range(0, 3) != 0), 1'b0, 1'b1);
                        default: send(rand_quire(), ($urandom_range(0, 7) == 0),
                                      ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
                    endcase
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    rtr_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
